mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Load/store bus engine that sits after the execute stage and consumes the decoder's memory controls (`mem_read`, `mem_write`, `inst_size`, `is_signed`) together with the ALU-computed address. It turns one accepted request into at most one word-aligned bus transaction with byte enables, and waits for the memory acknowledge. It then returns the aligned, sign- or zero-extended load data. The core is stalled via `busy` for the whole access.

## Interface
Parameters:
- `ACK_TIMEOUT`, default 16: maximum cycles `bus_req` is held without `bus_ack` before the access aborts with an error.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request valid; sampled only when `busy`=0.
- `mem_read`  in  1  load request.
- `mem_write`  in  1  store request; has priority if both it and `mem_read` are set.
- `inst_size`  in  2  access size: 00=WORD, 01=HALF, 10=BYTE; 11 is treated as WORD.
- `is_signed`  in  1  1 = sign-extend load data, 0 = zero-extend.
- `addr`  in  32  byte address.
- `wdata`  in  32  store data; the low byte or half is used for sub-word stores.
- `busy`  out  1  high from the cycle after accept until `done`; the core stalls while high.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  valid with `done`: misaligned access or ack timeout.
- `rdata`  out  32  extended load result; held until the next `done`.
- `bus_req`  out  1  bus transaction request.
- `bus_we`  out  1  1 = write.
- `bus_addr`  out  32  `{addr[31:2],2'b00}`.
- `bus_be`  out  4  byte enables.
- `bus_wdata`  out  32  lane-replicated store data.
- `bus_ack`  in  1  memory acknowledge, one cycle per transaction.
- `bus_rdata`  in  32  read data, valid with `bus_ack`.

## Operation
- State machine states: IDLE, REQ, RESP.
- IDLE:
  - On `start`=1, latch all request inputs.
  - If the request is a read or write and is aligned, go to REQ.
  - Otherwise go to RESP. This covers a misaligned access (`err`=1) and a request with neither `mem_read` nor `mem_write` set (`err`=0). Neither case issues a bus access.
- Alignment rules:
  - HALF requires `addr[0]`=0.
  - WORD requires `addr[1:0]`=00.
  - BYTE is always aligned.
- REQ:
  - `bus_req`=1 and all bus outputs are held stable.
  - Timeout counter increments every cycle.
  - On `bus_ack`=1: capture the extracted load data (reads only) and go to RESP.
  - If the counter reaches `ACK_TIMEOUT` with no ack: drop `bus_req`, set `err`=1, go to RESP.
- RESP: `done`=1 for one cycle, then return to IDLE.
- Byte enables and write data:
  - BYTE: `bus_be` = 0001<<`addr[1:0]`; `bus_wdata` = the low byte of `wdata` replicated ×4.
  - HALF: `bus_be` = 0011<<(2·`addr[1]`); `bus_wdata` = the low half of `wdata` replicated ×2.
  - WORD: `bus_be` = 1111.
- Load extraction:
  - Shift `bus_rdata` right by 8·`addr[1:0]`.
  - Keep the low 8 or 16 bits.
  - Extend per `is_signed`; WORD data passes through unchanged.
  - On a store or an error, `rdata` is unchanged.

## Timing
- Reset values (also forced asynchronously when `reset` goes low mid-access): state=IDLE; `busy`, `done`, `err`, `bus_req`, `bus_we`=0; `bus_be`=0000; `bus_addr`, `bus_wdata`, `rdata`=0.
- Reset during REQ drops `bus_req` immediately. No `done` is produced for the aborted access.
- Accept in cycle T. `busy` and `bus_req` are high from T+1.
- An ack sampled in cycle T+k gives `done` in T+k+1. `busy` falls in that same cycle.
- Minimum load/store latency: `done` at T+2 (ack in T+1).
- Non-bus requests (misaligned, or neither read nor write): `done` at T+1, with no bus activity.
- `start` is ignored while `busy`=1. A new `start` is accepted during the `done` cycle (state RESP counts as free; `busy`=0).
- `bus_ack` is ignored outside REQ.
- `bus_ack` arriving in the same cycle the timeout is reached: the ack wins, `err`=0.

## Structure
- Shared package holds the size codes (`WORD`=2'b00, `HALF`=2'b01, `BYTE`=2'b10), the state encoding, and the ALU/opcode constants already used by the decoder.
- One natural sub-module, `load_align`: combinational extraction and extension from (`bus_rdata`, `addr[1:0]`, size, `is_signed`).

## Test plan
- Signed byte load: `addr`=0x1003, BYTE, `is_signed`=1; `bus_rdata`=0x80_12_34_56 with ack 3 cycles after `bus_req`.
  - Expect `bus_addr`=0x1000, `bus_be`=1000, `rdata`=0xFFFFFF80, `done` one cycle after ack.
- Unsigned half load: `addr`=0x2002, HALF, `is_signed`=0; `bus_rdata`=0xBEEF_0000.
  - Expect `bus_be`=1100, `rdata`=0x0000BEEF.
- Byte store: `addr`=0x11, BYTE, `wdata`=0xAB.
  - Expect `bus_we`=1, `bus_be`=0010, `bus_wdata`=0xABABABAB; `rdata` unchanged.
- Misaligned word: `addr`=0x6.
  - Expect no `bus_req`, and `done`=1 with `err`=1 at T+1.
- Timeout: no ack, `ACK_TIMEOUT`=4.
  - Expect `bus_req` high for 4 cycles, then `done`+`err`.
  - Separately, ack in exactly the 4th cycle gives `err`=0.
- Reset mid-REQ: assert `reset` low while waiting.
  - Expect `bus_req`, `busy`=0 immediately, no `done`.
  - A new request after release completes normally.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared types for the load/store path: access sizes, the bus engine state
// encoding, and the decoder's ALU/opcode constants.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    WORD      = 2'b00,
    HALF      = 2'b01,
    BYTE      = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    RESP = 2'b10
  } state_e;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
  } alu_op_e;

  typedef enum logic [6:0] {
    OP_LOAD  = 7'b0000011,
    OP_STORE = 7'b0100011,
    OP_OPIMM = 7'b0010011,
    OP_OP    = 7'b0110011
  } opcode_e;

  // The reserved size code behaves as a full word everywhere downstream.
  function automatic size_e norm_size(input logic [1:0] s);
    return (s == 2'b11) ? WORD : size_e'(s);
  endfunction

  function automatic logic is_aligned(input size_e s, input logic [1:0] a);
    case (s)
      BYTE:    return 1'b1;
      HALF:    return ~a[0];
      default: return (a == 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input size_e s, input logic [1:0] a);
    case (s)
      BYTE:    return 4'b0001 << a;
      HALF:    return 4'b0011 << {a[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input size_e s, input logic [31:0] d);
    case (s)
      BYTE:    return {4{d[7:0]}};
      HALF:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Moves the addressed byte/half of a bus word down to bit 0 and extends it.
module load_align
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  size_e       size_i,
  input  logic        is_signed_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    shifted = rdata_i >> {addr_lo_i, 3'b000};
    data_o  = rdata_i;
    case (size_i)
      BYTE:    data_o = {{24{is_signed_i & shifted[7]}},  shifted[7:0]};
      HALF:    data_o = {{16{is_signed_i & shifted[15]}}, shifted[15:0]};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store bus engine: one accepted request becomes at most one word-aligned
// bus transaction, with stall, completion pulse and extended load data.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  inst_size,
  input  logic        is_signed,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  state_e      state_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]  addr_lo_q;
  size_e       size_q;
  logic        signed_q, we_q;
  logic        busy_q, done_q, err_q, bus_req_q, bus_we_q;
  logic [31:0] rdata_q, bus_addr_q, bus_wdata_q;
  logic [3:0]  bus_be_q;

  size_e       size_d;
  logic        bus_op_d, aligned_d;
  logic [31:0] load_data;

  assign size_d    = norm_size(inst_size);
  assign bus_op_d  = mem_read | mem_write;
  assign aligned_d = is_aligned(size_d, addr[1:0]);

  load_align u_load_align (
    .rdata_i     (bus_rdata),
    .addr_lo_i   (addr_lo_q),
    .size_i      (size_q),
    .is_signed_i (signed_q),
    .data_o      (load_data)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_lo_q   <= 2'b00;
      size_q      <= WORD;
      signed_q    <= 1'b0;
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      rdata_q     <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_be_q    <= 4'b0000;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        REQ: begin
          if (bus_ack || cnt_q == CW'(ACK_TIMEOUT - 1)) begin
            state_q   <= RESP;
            done_q    <= 1'b1;
            err_q     <= ~bus_ack;
            busy_q    <= 1'b0;
            bus_req_q <= 1'b0;
            bus_we_q  <= 1'b0;
            if (bus_ack && !we_q) rdata_q <= load_data;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        // IDLE and the RESP (done) cycle both accept a new request.
        default: begin
          state_q <= IDLE;
          if (start) begin
            addr_lo_q <= addr[1:0];
            size_q    <= size_d;
            signed_q  <= is_signed;
            we_q      <= mem_write;
            if (bus_op_d && aligned_d) begin
              state_q     <= REQ;
              cnt_q       <= '0;
              busy_q      <= 1'b1;
              bus_req_q   <= 1'b1;
              bus_we_q    <= mem_write;
              bus_addr_q  <= {addr[31:2], 2'b00};
              bus_be_q    <= byte_en(size_d, addr[1:0]);
              bus_wdata_q <= lane_data(size_d, wdata);
            end else begin
              state_q <= RESP;
              done_q  <= 1'b1;
              err_q   <= bus_op_d;
            end
          end
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, misalignment, timeout,
// back-to-back accept and asynchronous reset mid-access.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, mem_read, mem_write, is_signed;
  logic [1:0]  inst_size;
  logic [31:0] addr, wdata;
  logic        busy, done, err, bus_req, bus_we, bus_ack;
  logic [31:0] rdata, bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  int tests = 0;
  int fails = 0;

  mem_access_unit #(.ACK_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .start(start), .mem_read(mem_read),
    .mem_write(mem_write), .inst_size(inst_size), .is_signed(is_signed),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
    .rdata(rdata), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, required finish before 100000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic sg, input logic [31:0] a, input logic [31:0] wd);
    start = 1'b1; mem_read = rd; mem_write = wr; inst_size = sz;
    is_signed = sg; addr = a; wdata = wd;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    inst_size = 2'b00; is_signed = 1'b0; addr = '0; wdata = '0;
    bus_ack = 1'b0; bus_rdata = '0;

    // Reset state
    step(); step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_bus_be", 32'(bus_be), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    reset = 1'b1;
    step();

    // Signed byte load at 0x1003, ack in the third REQ cycle
    issue(1'b1, 1'b0, 2'b10, 1'b1, 32'h0000_1003, 32'h0);
    step(); start = 1'b0;
    check("lb_busy", 32'(busy), 32'd1);
    check("lb_bus_req", 32'(bus_req), 32'd1);
    check("lb_bus_we", 32'(bus_we), 32'd0);
    check("lb_bus_addr", bus_addr, 32'h0000_1000);
    check("lb_bus_be", 32'(bus_be), 32'b1000);
    step();
    check("lb_req_held", 32'(bus_req), 32'd1);
    step(); bus_ack = 1'b1; bus_rdata = 32'h8012_3456;
    step(); bus_ack = 1'b0;
    check("lb_done", 32'(done), 32'd1);
    check("lb_err", 32'(err), 32'd0);
    check("lb_busy_fall", 32'(busy), 32'd0);
    check("lb_rdata", rdata, 32'hFFFF_FF80);
    step();
    check("lb_done_pulse", 32'(done), 32'd0);
    check("lb_rdata_held", rdata, 32'hFFFF_FF80);

    // Unsigned half load at 0x2002, minimum latency
    issue(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'h0);
    step(); start = 1'b0;
    check("lh_bus_be", 32'(bus_be), 32'b1100);
    check("lh_bus_addr", bus_addr, 32'h0000_2000);
    bus_ack = 1'b1; bus_rdata = 32'hBEEF_0000;
    step(); bus_ack = 1'b0;
    check("lh_done", 32'(done), 32'd1);
    check("lh_rdata", rdata, 32'h0000_BEEF);
    step();

    // Byte store at 0x11
    issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0011, 32'h1234_56AB);
    step(); start = 1'b0;
    check("sb_bus_we", 32'(bus_we), 32'd1);
    check("sb_bus_be", 32'(bus_be), 32'b0010);
    check("sb_bus_wdata", bus_wdata, 32'hABAB_ABAB);
    check("sb_bus_addr", bus_addr, 32'h0000_0010);
    bus_ack = 1'b1; bus_rdata = 32'hDEAD_DEAD;
    step(); bus_ack = 1'b0;
    check("sb_done", 32'(done), 32'd1);
    check("sb_err", 32'(err), 32'd0);
    check("sb_rdata_kept", rdata, 32'h0000_BEEF);
    step();

    // Misaligned word at 0x6, with a new word request accepted in the done cycle
    issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0006, 32'h0);
    step();
    check("mis_done", 32'(done), 32'd1);
    check("mis_err", 32'(err), 32'd1);
    check("mis_bus_req", 32'(bus_req), 32'd0);
    check("mis_busy", 32'(busy), 32'd0);
    issue(1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_0040, 32'h0);
    step(); start = 1'b0;
    check("b2b_bus_req", 32'(bus_req), 32'd1);
    check("b2b_bus_be", 32'(bus_be), 32'b1111);
    bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
    step(); bus_ack = 1'b0;
    check("b2b_done", 32'(done), 32'd1);
    check("b2b_rdata", rdata, 32'hCAFE_F00D);
    step();

    // Neither read nor write: done without error or bus activity
    issue(1'b0, 1'b0, 2'b00, 1'b0, 32'h0000_0003, 32'h0);
    step(); start = 1'b0;
    check("nop_done", 32'(done), 32'd1);
    check("nop_err", 32'(err), 32'd0);
    check("nop_bus_req", 32'(bus_req), 32'd0);
    step();

    // Timeout: no ack for four REQ cycles; a start while busy is ignored
    issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0100, 32'h0);
    step(); start = 1'b0;
    check("to_req_c1", 32'(bus_req), 32'd1);
    issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0200, 32'hFF);
    step(); start = 1'b0;
    check("to_req_c2", 32'(bus_req), 32'd1);
    step();
    check("to_req_c3", 32'(bus_req), 32'd1);
    check("to_ignore_start", 32'(bus_we), 32'd0);
    check("to_ignore_addr", bus_addr, 32'h0000_0100);
    step();
    check("to_req_c4", 32'(bus_req), 32'd1);
    check("to_no_done_yet", 32'(done), 32'd0);
    step();
    check("to_done", 32'(done), 32'd1);
    check("to_err", 32'(err), 32'd1);
    check("to_req_drop", 32'(bus_req), 32'd0);
    check("to_rdata_kept", rdata, 32'hCAFE_F00D);
    step();

    // Ack in exactly the fourth REQ cycle wins over the timeout
    issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0104, 32'h0);
    step(); start = 1'b0;
    step(); step(); step();
    check("ack4_req", 32'(bus_req), 32'd1);
    bus_ack = 1'b1; bus_rdata = 32'h1122_3344;
    step(); bus_ack = 1'b0;
    check("ack4_done", 32'(done), 32'd1);
    check("ack4_err", 32'(err), 32'd0);
    check("ack4_rdata", rdata, 32'h1122_3344);
    step();

    // Reset while waiting in REQ: outputs drop at once, no done
    issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0108, 32'h0);
    step(); start = 1'b0;
    check("rr_req_before", 32'(bus_req), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("rr_req_async", 32'(bus_req), 32'd0);
    check("rr_busy_async", 32'(busy), 32'd0);
    check("rr_rdata_cleared", rdata, 32'd0);
    step(); reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rr_no_done", 32'(done), 32'd0);
    end

    // New request after release: signed half load completes normally
    issue(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_3000, 32'h0);
    step(); start = 1'b0;
    check("post_bus_be", 32'(bus_be), 32'b0011);
    bus_ack = 1'b1; bus_rdata = 32'h0000_8001;
    step(); bus_ack = 1'b0;
    check("post_done", 32'(done), 32'd1);
    check("post_rdata", rdata, 32'hFFFF_8001);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
